uart_cmd_receiver: RTL and testbench
====================================

Name: uart_cmd_receiver

Overview:
UART receive path plus command-frame parser. It is the host-to-board direction of the telemetry link; the board-to-host direction is driven by async_transmitter.
- Samples the host RxD line and reassembles bytes (8N1, LSB first).
- Parses ASCII command frames of the form 'c' <code> <hexHi> <hexLo> '\r'.
- Delivers each complete command as a one-cycle strobe with code and argument, for use by the top-level control logic (LED control, measurement triggers, bill-validator commands).

Parameters:
ClkFrequency, 10000000, input clock frequency in Hz.
Baud, 230400, line rate. Bit period BIT_TICKS = (ClkFrequency + Baud/2)/Baud = 43; HALF_TICKS = BIT_TICKS/2 = 21.
TimeoutClks, 5000, maximum idle clocks between bytes inside a frame before the frame is aborted.

Ports:
clk  in  1  single system clock (10 MHz CLK_SE_AR at top level)
rst  in  1  synchronous, active-high reset
RxD  in  1  asynchronous serial input; idle high
rx_data  out  8  last received byte; valid when rx_strobe=1
rx_strobe  out  1  one-cycle pulse per correctly framed byte
cmd_valid  out  1  one-cycle pulse per complete, valid command frame
cmd_code  out  8  command character; held until the next cmd_valid
cmd_arg  out  8  argument decoded from the two hex digits; held until the next cmd_valid
frame_err  out  1  one-cycle pulse when a stop bit is sampled as 0
parse_err  out  1  one-cycle pulse on a malformed frame or a timeout
busy  out  1  high while the byte receiver is not in IDLE

Behaviour:
- Reset: one clock, synchronous, active-high. Reset values: all outputs 0; synchronizer flops 1; receiver state IDLE; parser state P_IDLE; all counters 0. Reset mid-byte or mid-frame discards the partial data with no pulses.
- Input: RxD passes through a 2-flop synchronizer. All decisions use the second flop (rxs).
- Byte receiver FSM:
  - IDLE: when rxs=0, go to START and clear the tick counter.
  - START: after HALF_TICKS clocks, sample rxs. If 1, it is a glitch: return to IDLE with no pulse. If 0, go to DATA with bit index 0.
  - DATA: sample every BIT_TICKS clocks and shift LSB first. After bit 7, go to STOP.
  - STOP: sample after BIT_TICKS clocks.
    - rxs=1: rx_data is updated, rx_strobe pulses on the next cycle, and the FSM returns to IDLE.
    - rxs=0: frame_err pulses, rx_data is unchanged, and the FSM goes to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE.
- busy = (state != IDLE).
- Latency: rx_strobe rises 2 (sync) + HALF_TICKS + 9*BIT_TICKS + 1 clocks after the start-bit falling edge on RxD = 411 clocks at the defaults.
- Parser FSM (advances only on rx_strobe):
  - P_IDLE: on 'c' (0x63), go to P_CODE; all other bytes are ignored.
  - P_CODE: latch any byte in 0x21..0x7E except 'c'; go to P_HI. A byte outside that range gives parse_err and a return to P_IDLE.
  - P_HI / P_LO: accept '0'-'9', 'A'-'F', 'a'-'f' and convert to a nibble. Any other byte gives parse_err and P_IDLE.
  - P_END: '\r' (0x0D) moves the latched code/argument to cmd_code/cmd_arg and pulses cmd_valid on the next cycle. Any other byte gives parse_err and P_IDLE.
- Resync: 'c' received in any non-idle parser state pulses parse_err and restarts at P_CODE.
- frame_err while the parser is non-idle: parser returns to P_IDLE without a parse_err pulse.
- Timeout: the timeout counter runs only while the parser is non-idle and resets on each rx_strobe. Reaching TimeoutClks gives parse_err and P_IDLE. The counter saturates and does not wrap.
- Simultaneous events: rx_strobe and a timeout in the same cycle means the byte wins and the timeout is ignored.

Decomposition:
- Shared package/include holds:
  - ASCII constants: CMD_START='c', CR=0x0D.
  - Receiver state encodings: IDLE, START, DATA, STOP, BREAK.
  - Parser state encodings: P_IDLE, P_CODE, P_HI, P_LO, P_END.
  - A hex-to-nibble function with a valid flag.
- One sub-module, uart_rx_core: synchronizer and byte FSM (ports rx_data, rx_strobe, frame_err, busy).
- The parser and timeout logic stay in uart_cmd_receiver.

Test Plan:
- Valid frame: send bytes 0x63,0x4C,0x33,0x46,0x0D at 43 clk/bit -> exactly five rx_strobe pulses, one cmd_valid, cmd_code=0x4C, cmd_arg=0x3F, no error pulses.
- Glitch rejection: drive RxD low for 10 clocks, then high -> no rx_strobe and no frame_err; busy drops within 24 clocks.
- Framing error: byte 0x55 with a stop bit of 0, then RxD low for 3 bit times, then high -> one frame_err pulse, no rx_strobe, rx_data unchanged. A following valid byte 0x41 gives rx_strobe with rx_data=0x41.
- Bad hex: send 'c','L','G' -> parse_err on the 'G' byte, no cmd_valid. A following full frame 'c','x','a','0','\r' gives cmd_code=0x78, cmd_arg=0xA0.
- Timeout: send 'c','L', then idle -> parse_err exactly 5000 clocks after the second rx_strobe. A subsequent '3','F','\r' does not produce cmd_valid.
- Reset mid-byte: assert rst for 1 cycle during DATA of 'c', then send a full frame -> all outputs at 0 after reset, and the correct single cmd_valid with no stale pulses.

Source files
------------

// File: rtl/uart_cmd_receiver_pkg.sv
// Shared constants, state encodings and the hex-digit decoder for the
// host-to-board command receiver.
package uart_cmd_receiver_pkg;

    localparam logic [7:0] CMD_START = 8'h63;
    localparam logic [7:0] CR        = 8'h0D;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rxState_t;
    typedef enum logic [2:0] {P_IDLE, P_CODE, P_HI, P_LO, P_END} parseState_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } hexNib_t;

    // Letters map through their low nibble: 'A'/'a' = x1 -> 10 ... 'F'/'f' = x6 -> 15.
    function automatic hexNib_t hexToNibble(input logic [7:0] ch);
        hexNib_t r;
        r.valid  = 1'b1;
        r.nibble = '0;
        if (ch >= 8'h30 && ch <= 8'h39)
            r.nibble = ch[3:0];
        else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66))
            r.nibble = ch[3:0] + 4'd9;
        else
            r.valid = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 byte receiver: two-flop synchronizer, mid-bit sampling, glitch
// rejection on the start bit and a BREAK state that waits out a low line.
module uart_rx_core
    import uart_cmd_receiver_pkg::*;
#(
    parameter int ClkFrequency = 10000000,
    parameter int Baud         = 230400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] rx_data,
    output logic       rx_strobe,
    output logic       frame_err,
    output logic       busy
);

    localparam int BIT_TICKS  = (ClkFrequency + Baud / 2) / Baud;
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int TICK_W     = $clog2(BIT_TICKS + 1);

    logic              rxMeta;
    logic              rxs;
    rxState_t          state;
    logic [TICK_W-1:0] tickCnt;
    logic [2:0]        bitIdx;
    logic [7:0]        shiftReg;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta    <= 1'b1;
            rxs       <= 1'b1;
            state     <= IDLE;
            tickCnt   <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            rx_data   <= '0;
            rx_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rxMeta    <= RxD;
            rxs       <= rxMeta;
            rx_strobe <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state   <= START;
                        tickCnt <= '0;
                    end
                end
                START: begin
                    // A start bit that is high again at its midpoint was noise.
                    if (tickCnt == TICK_W'(HALF_TICKS - 1)) begin
                        tickCnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            state  <= DATA;
                            bitIdx <= '0;
                        end
                    end else begin
                        tickCnt <= tickCnt + TICK_W'(1);
                    end
                end
                DATA: begin
                    if (tickCnt == TICK_W'(BIT_TICKS - 1)) begin
                        tickCnt  <= '0;
                        shiftReg <= {rxs, shiftReg[7:1]};
                        bitIdx   <= bitIdx + 3'd1;
                        if (bitIdx == 3'd7)
                            state <= STOP;
                    end else begin
                        tickCnt <= tickCnt + TICK_W'(1);
                    end
                end
                STOP: begin
                    if (tickCnt == TICK_W'(BIT_TICKS - 1)) begin
                        tickCnt <= '0;
                        if (rxs) begin
                            rx_data   <= shiftReg;
                            rx_strobe <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        tickCnt <= tickCnt + TICK_W'(1);
                    end
                end
                BREAK: begin
                    if (rxs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_receiver.sv
// Command-frame parser on top of the byte receiver: 'c' <code> <hexHi> <hexLo> CR
// becomes one cmd_valid pulse carrying the code and the decoded argument.
module uart_cmd_receiver
    import uart_cmd_receiver_pkg::*;
#(
    parameter int ClkFrequency = 10000000,
    parameter int Baud         = 230400,
    parameter int TimeoutClks  = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] rx_data,
    output logic       rx_strobe,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic [7:0] cmd_arg,
    output logic       frame_err,
    output logic       parse_err,
    output logic       busy
);

    localparam int TO_W = $clog2(TimeoutClks + 1);

    parseState_t     pState;
    logic [7:0]      codeLatch;
    logic [3:0]      hiNib;
    logic [7:0]      argLatch;
    logic [TO_W-1:0] timeoutCnt;
    hexNib_t         hexDec;

    uart_rx_core #(
        .ClkFrequency(ClkFrequency),
        .Baud        (Baud)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .RxD      (RxD),
        .rx_data  (rx_data),
        .rx_strobe(rx_strobe),
        .frame_err(frame_err),
        .busy     (busy)
    );

    assign hexDec = hexToNibble(rx_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            pState     <= P_IDLE;
            codeLatch  <= '0;
            hiNib      <= '0;
            argLatch   <= '0;
            timeoutCnt <= '0;
            cmd_valid  <= 1'b0;
            cmd_code   <= '0;
            cmd_arg    <= '0;
            parse_err  <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            parse_err <= 1'b0;
            if (rx_strobe) begin
                // The strobe cycle counts as the first idle clock after the byte.
                timeoutCnt <= TO_W'(1);
                if (pState != P_IDLE && rx_data == CMD_START) begin
                    parse_err <= 1'b1;
                    pState    <= P_CODE;
                end else begin
                    case (pState)
                        P_IDLE: begin
                            if (rx_data == CMD_START)
                                pState <= P_CODE;
                        end
                        P_CODE: begin
                            if (rx_data >= 8'h21 && rx_data <= 8'h7E) begin
                                codeLatch <= rx_data;
                                pState    <= P_HI;
                            end else begin
                                parse_err <= 1'b1;
                                pState    <= P_IDLE;
                            end
                        end
                        P_HI: begin
                            if (hexDec.valid) begin
                                hiNib  <= hexDec.nibble;
                                pState <= P_LO;
                            end else begin
                                parse_err <= 1'b1;
                                pState    <= P_IDLE;
                            end
                        end
                        P_LO: begin
                            if (hexDec.valid) begin
                                argLatch <= {hiNib, hexDec.nibble};
                                pState   <= P_END;
                            end else begin
                                parse_err <= 1'b1;
                                pState    <= P_IDLE;
                            end
                        end
                        P_END: begin
                            if (rx_data == CR) begin
                                cmd_code  <= codeLatch;
                                cmd_arg   <= argLatch;
                                cmd_valid <= 1'b1;
                            end else begin
                                parse_err <= 1'b1;
                            end
                            pState <= P_IDLE;
                        end
                        default: pState <= P_IDLE;
                    endcase
                end
            end else if (frame_err) begin
                pState     <= P_IDLE;
                timeoutCnt <= '0;
            end else if (pState == P_IDLE) begin
                timeoutCnt <= '0;
            end else if (timeoutCnt == TO_W'(TimeoutClks - 1)) begin
                parse_err  <= 1'b1;
                pState     <= P_IDLE;
                timeoutCnt <= '0;
            end else if (timeoutCnt != TO_W'(TimeoutClks)) begin
                timeoutCnt <= timeoutCnt + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Bench for uart_cmd_receiver: serial byte driver, byte/command scoreboards
// and pulse counters checked per scenario.
`timescale 1ns/1ps
module tb_uart_cmd_receiver;

    localparam int BIT = 43;

    logic       clk;
    logic       rst;
    logic       RxD;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic [7:0] cmd_arg;
    logic       frame_err;
    logic       parse_err;
    logic       busy;

    logic [7:0]  exp_q[$];
    logic [15:0] cmd_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int startCyc = 0;
    bit latArmed = 0;
    int lastStrobeCyc = 0;
    int parseGap = 0;
    int strobeCnt = 0, cmdCnt = 0, frameCnt = 0, parseCnt = 0;
    int bStrobe, bCmd, bFrame, bParse;
    logic [7:0] lastGood = 8'h00;

    uart_cmd_receiver dut (
        .clk      (clk),
        .rst      (rst),
        .RxD      (RxD),
        .rx_data  (rx_data),
        .rx_strobe(rx_strobe),
        .cmd_valid(cmd_valid),
        .cmd_code (cmd_code),
        .cmd_arg  (cmd_arg),
        .frame_err(frame_err),
        .parse_err(parse_err),
        .busy     (busy)
    );

    // clock / reset infrastructure
    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #8000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopBit, input logic armLat);
        @(posedge clk);
        #1;
        if (stopBit) exp_q.push_back(b);
        startCyc = cyc;
        latArmed = armLat;
        RxD = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            tick(BIT);
        end
        RxD = stopBit;
        tick(BIT);
        if (stopBit) lastGood = b;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic [7:0] hi, input logic [7:0] lo);
        send_byte(8'h63, 1'b1, 1'b0);
        send_byte(code, 1'b1, 1'b0);
        send_byte(hi, 1'b1, 1'b0);
        send_byte(lo, 1'b1, 1'b0);
        send_byte(8'h0D, 1'b1, 1'b0);
    endtask

    task automatic snap();
        bStrobe = strobeCnt;
        bCmd    = cmdCnt;
        bFrame  = frameCnt;
        bParse  = parseCnt;
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n, input logic up);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return (up ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    // scoreboard / monitor
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (rx_strobe) begin
                strobeCnt++;
                lastStrobeCyc = cyc;
                if (latArmed) begin
                    chk("rx_latency", 32'(cyc - startCyc), 32'd411);
                    latArmed = 0;
                end
                if (exp_q.size() == 0) chk("rx_extra", 32'd1, 32'd0);
                else chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
            if (cmd_valid) begin
                cmdCnt++;
                if (cmd_q.size() == 0) chk("cmd_extra", 32'd1, 32'd0);
                else chk("cmd", 32'({cmd_code, cmd_arg}), 32'(cmd_q.pop_front()));
            end
            if (frame_err) frameCnt++;
            if (parse_err) begin
                parseCnt++;
                parseGap = cyc - lastStrobeCyc;
            end
        end
    end

    initial begin
        logic [7:0] code, arg;
        rst = 1'b1;
        RxD = 1'b1;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outs", 32'({rx_data, rx_strobe, cmd_valid, cmd_code, cmd_arg,
                                frame_err, parse_err, busy}), 32'd0);
        tick(10);

        // valid frame
        snap();
        cmd_q.push_back(16'h4C3F);
        send_byte(8'h63, 1'b1, 1'b1);
        send_byte(8'h4C, 1'b1, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);
        send_byte(8'h46, 1'b1, 1'b0);
        send_byte(8'h0D, 1'b1, 1'b0);
        tick(20);
        chk("valid_strobes", 32'(strobeCnt - bStrobe), 32'd5);
        chk("valid_cmds", 32'(cmdCnt - bCmd), 32'd1);
        chk("valid_errs", 32'((frameCnt - bFrame) + (parseCnt - bParse)), 32'd0);
        chk("cmd_hold", 32'({cmd_code, cmd_arg}), 32'h4C3F);

        // glitch rejection
        snap();
        @(posedge clk);
        #1;
        RxD = 1'b0;
        tick(10);
        chk("glitch_busy_hi", 32'(busy), 32'd1);
        RxD = 1'b1;
        for (int i = 0; i < 24 && busy; i++) @(negedge clk);
        chk("glitch_busy_lo", 32'(busy), 32'd0);
        tick(100);
        chk("glitch_strobes", 32'(strobeCnt - bStrobe), 32'd0);
        chk("glitch_frame", 32'(frameCnt - bFrame), 32'd0);

        // framing error then recovery
        snap();
        send_byte(8'h55, 1'b0, 1'b0);
        tick(3 * BIT);
        RxD = 1'b1;
        tick(2 * BIT);
        chk("ferr_pulses", 32'(frameCnt - bFrame), 32'd1);
        chk("ferr_strobes", 32'(strobeCnt - bStrobe), 32'd0);
        chk("ferr_rx_hold", 32'(rx_data), 32'(lastGood));
        send_byte(8'h41, 1'b1, 1'b0);
        tick(5);
        chk("ferr_recover", 32'(strobeCnt - bStrobe), 32'd1);

        // framing error inside a frame drops the frame silently
        snap();
        send_byte(8'h63, 1'b1, 1'b0);
        send_byte(8'h31, 1'b0, 1'b0);
        tick(3 * BIT);
        RxD = 1'b1;
        tick(2 * BIT);
        send_byte(8'h33, 1'b1, 1'b0);
        send_byte(8'h46, 1'b1, 1'b0);
        send_byte(8'h0D, 1'b1, 1'b0);
        tick(10);
        chk("pferr_frame", 32'(frameCnt - bFrame), 32'd1);
        chk("pferr_parse", 32'(parseCnt - bParse), 32'd0);
        chk("pferr_cmds", 32'(cmdCnt - bCmd), 32'd0);

        // bad hex digit, then a good frame
        snap();
        send_byte(8'h63, 1'b1, 1'b0);
        send_byte(8'h4C, 1'b1, 1'b0);
        send_byte(8'h47, 1'b1, 1'b0);
        tick(5);
        chk("badhex_parse", 32'(parseCnt - bParse), 32'd1);
        chk("badhex_gap", 32'(parseGap), 32'd1);
        chk("badhex_cmds", 32'(cmdCnt - bCmd), 32'd0);
        cmd_q.push_back(16'h78A0);
        send_frame(8'h78, 8'h61, 8'h30);
        tick(10);
        chk("after_badhex_cmds", 32'(cmdCnt - bCmd), 32'd1);

        // inter-byte timeout
        snap();
        send_byte(8'h63, 1'b1, 1'b0);
        send_byte(8'h4C, 1'b1, 1'b0);
        for (int i = 0; i < 6000 && parseCnt == bParse; i++) @(negedge clk);
        chk("timeout_parse", 32'(parseCnt - bParse), 32'd1);
        chk("timeout_gap", 32'(parseGap), 32'd5000);
        send_byte(8'h33, 1'b1, 1'b0);
        send_byte(8'h46, 1'b1, 1'b0);
        send_byte(8'h0D, 1'b1, 1'b0);
        tick(10);
        chk("timeout_cmds", 32'(cmdCnt - bCmd), 32'd0);
        chk("timeout_parse_total", 32'(parseCnt - bParse), 32'd1);

        // random frames
        snap();
        for (int n = 0; n < 4; n++) begin
            code = 8'($urandom_range(8'h21, 8'h7E));
            if (code == 8'h63) code = 8'h64;
            arg = 8'($urandom_range(0, 255));
            cmd_q.push_back({code, arg});
            send_frame(code, hex_char(arg[7:4], 1'($urandom_range(0, 1))),
                       hex_char(arg[3:0], 1'($urandom_range(0, 1))));
        end
        tick(10);
        chk("rand_cmds", 32'(cmdCnt - bCmd), 32'd4);
        chk("rand_errs", 32'((frameCnt - bFrame) + (parseCnt - bParse)), 32'd0);

        // reset in the middle of a byte inside a frame
        send_byte(8'h63, 1'b1, 1'b0);
        send_byte(8'h51, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        RxD = 1'b0;
        tick(BIT);
        RxD = 1'b1;
        tick(BIT);
        RxD = 1'b1;
        tick(20);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_reset_outs", 32'({rx_data, rx_strobe, cmd_valid, cmd_code, cmd_arg,
                                    frame_err, parse_err, busy}), 32'd0);
        snap();
        cmd_q.push_back(16'h5A12);
        send_frame(8'h5A, 8'h31, 8'h32);
        tick(10);
        chk("mid_cmds", 32'(cmdCnt - bCmd), 32'd1);
        chk("mid_errs", 32'((frameCnt - bFrame) + (parseCnt - bParse)), 32'd0);

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
